// File: rtl/dma_pkg.sv
// Shared definitions for the 8237-style DMA CPU register interface:
// register address map and the decoded access kinds.
package dma_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_SEL_W = $clog2(NUM_CH);

  localparam logic [3:0] ADDR_CMD_STATUS   = 4'h8;
  localparam logic [3:0] ADDR_REQUEST      = 4'h9;
  localparam logic [3:0] ADDR_SINGLE_MASK  = 4'hA;
  localparam logic [3:0] ADDR_MODE         = 4'hB;
  localparam logic [3:0] ADDR_CLEAR_FF     = 4'hC;
  localparam logic [3:0] ADDR_MASTER_CLEAR = 4'hD;
  localparam logic [3:0] ADDR_CLEAR_MASK   = 4'hE;
  localparam logic [3:0] ADDR_ALL_MASK     = 4'hF;

  typedef enum logic [3:0] {
    ACC_NONE,
    ACC_LOAD_CMD,
    ACC_READ_STATUS,
    ACC_LOAD_REQUEST,
    ACC_LOAD_SINGLE_MASK,
    ACC_LOAD_MODE,
    ACC_CLEAR_FF,
    ACC_MASTER_CLEAR,
    ACC_READ_TEMP,
    ACC_CLEAR_MASK,
    ACC_LOAD_ALL_MASK,
    ACC_LOAD_BASE_ADDR,
    ACC_LOAD_BASE_COUNT,
    ACC_READ_CUR_ADDR,
    ACC_READ_CUR_COUNT
  } regAccess_t;

  // Channel registers live in the lower half of the address map.
  function automatic logic isChannelAddr(input logic [3:0] addr);
    return ~addr[3];
  endfunction

endpackage

// File: rtl/dma_byte_pointer.sv
// Byte-pointer flip-flop: toggles once at the end of each channel-register
// access, and is cleared by clear-FF or master-clear writes.
module dma_byte_pointer (
  input  logic CLK,
  input  logic RESET_N,
  input  logic chAcc,
  input  logic clearFF,
  output logic internalFF
);

  logic chAccQ;

  // Clear has priority so a clear landing on an access end leaves the pointer at 0.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      chAccQ     <= 1'b0;
      internalFF <= 1'b0;
    end else begin
      chAccQ <= chAcc;
      if (clearFF)
        internalFF <= 1'b0;
      else if (chAccQ && !chAcc)
        internalFF <= ~internalFF;
    end
  end

endmodule

// File: rtl/dma_reg_access_decoder.sv
// CPU-side register decode for the DMA controller: one-hot load/read strobes
// from CS_N/IOR_N/IOW_N/A plus the byte-pointer flip-flop.
module dma_reg_access_decoder
  import dma_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                CS_N,
  input  logic                IOR_N,
  input  logic                IOW_N,
  input  logic [3:0]          A,
  input  logic                programCondition,
  output logic                loadCommandReg,
  output logic                readStatusReg,
  output logic                loadIoDataBufferFromStatus,
  output logic                loadRequestReg,
  output logic                loadSingleMask,
  output logic                loadModeReg,
  output logic                clearInternalFF,
  output logic                masterClear,
  output logic                readTemporaryReg,
  output logic                clearMaskReg,
  output logic                loadAllMask,
  output logic                loadBaseAddressReg,
  output logic                loadBaseWordCountReg,
  output logic                readCurrentAddressReg,
  output logic                readCurrentWordCountReg,
  output logic [CH_SEL_W-1:0] channelSel,
  output logic                internalFF
);

  logic       prog, wr, rd, chAcc;
  regAccess_t access;

  // Reset gates the qualifier so every strobe is 0 while RESET_N is low.
  assign prog  = RESET_N & ~CS_N & programCondition;
  assign wr    = prog & ~IOW_N & IOR_N;
  assign rd    = prog & ~IOR_N & IOW_N;
  assign chAcc = isChannelAddr(A) & (wr | rd);

  always_comb begin
    access = ACC_NONE;
    if (wr) begin
      if (isChannelAddr(A)) begin
        access = A[0] ? ACC_LOAD_BASE_COUNT : ACC_LOAD_BASE_ADDR;
      end else begin
        case (A)
          ADDR_CMD_STATUS:   access = ACC_LOAD_CMD;
          ADDR_REQUEST:      access = ACC_LOAD_REQUEST;
          ADDR_SINGLE_MASK:  access = ACC_LOAD_SINGLE_MASK;
          ADDR_MODE:         access = ACC_LOAD_MODE;
          ADDR_CLEAR_FF:     access = ACC_CLEAR_FF;
          ADDR_MASTER_CLEAR: access = ACC_MASTER_CLEAR;
          ADDR_CLEAR_MASK:   access = ACC_CLEAR_MASK;
          ADDR_ALL_MASK:     access = ACC_LOAD_ALL_MASK;
          default:           access = ACC_NONE;
        endcase
      end
    end else if (rd) begin
      if (isChannelAddr(A)) begin
        access = A[0] ? ACC_READ_CUR_COUNT : ACC_READ_CUR_ADDR;
      end else begin
        case (A)
          ADDR_CMD_STATUS:   access = ACC_READ_STATUS;
          ADDR_MASTER_CLEAR: access = ACC_READ_TEMP;
          default:           access = ACC_NONE;
        endcase
      end
    end
  end

  assign loadCommandReg             = (access == ACC_LOAD_CMD);
  assign readStatusReg              = (access == ACC_READ_STATUS);
  assign loadIoDataBufferFromStatus = (access == ACC_READ_STATUS);
  assign loadRequestReg             = (access == ACC_LOAD_REQUEST);
  assign loadSingleMask             = (access == ACC_LOAD_SINGLE_MASK);
  assign loadModeReg                = (access == ACC_LOAD_MODE);
  assign clearInternalFF            = (access == ACC_CLEAR_FF);
  assign masterClear                = (access == ACC_MASTER_CLEAR);
  assign readTemporaryReg           = (access == ACC_READ_TEMP);
  assign clearMaskReg               = (access == ACC_CLEAR_MASK);
  assign loadAllMask                = (access == ACC_LOAD_ALL_MASK);
  assign loadBaseAddressReg         = (access == ACC_LOAD_BASE_ADDR);
  assign loadBaseWordCountReg       = (access == ACC_LOAD_BASE_COUNT);
  assign readCurrentAddressReg      = (access == ACC_READ_CUR_ADDR);
  assign readCurrentWordCountReg    = (access == ACC_READ_CUR_COUNT);

  assign channelSel = chAcc ? A[CH_SEL_W:1] : '0;

  dma_byte_pointer uBytePointer (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .chAcc      (chAcc),
    .clearFF    (clearInternalFF | masterClear),
    .internalFF (internalFF)
  );

endmodule

// File: tb/tb_dma_reg_access_decoder.sv
// Self-checking bench for dma_reg_access_decoder: directed steps then random
// bus cycles, compared against a table-driven reference model.
module tb_dma_reg_access_decoder;

  logic       CLK, RESET_N, CS_N, IOR_N, IOW_N, programCondition;
  logic [3:0] A;
  logic       loadCommandReg, readStatusReg, loadIoDataBufferFromStatus;
  logic       loadRequestReg, loadSingleMask, loadModeReg, clearInternalFF;
  logic       masterClear, readTemporaryReg, clearMaskReg, loadAllMask;
  logic       loadBaseAddressReg, loadBaseWordCountReg;
  logic       readCurrentAddressReg, readCurrentWordCountReg;
  logic [1:0] channelSel;
  logic       internalFF;

  int passCount = 0;
  int totalCount = 0;

  localparam int B_CMD = 14, B_STATUS = 13, B_IOBUF = 12, B_REQ = 11;
  localparam int B_SMASK = 10, B_MODE = 9, B_CLRFF = 8, B_MCLR = 7;
  localparam int B_TEMP = 6, B_CLRMASK = 5, B_ALLMASK = 4, B_BASEADDR = 3;
  localparam int B_BASECNT = 2, B_CURADDR = 1, B_CURCNT = 0;

  // Register map as the CPU sees it: which strobe each address raises.
  int wrBit [16] = '{B_BASEADDR, B_BASECNT, B_BASEADDR, B_BASECNT,
                     B_BASEADDR, B_BASECNT, B_BASEADDR, B_BASECNT,
                     B_CMD, B_REQ, B_SMASK, B_MODE,
                     B_CLRFF, B_MCLR, B_CLRMASK, B_ALLMASK};
  int rdBit [16] = '{B_CURADDR, B_CURCNT, B_CURADDR, B_CURCNT,
                     B_CURADDR, B_CURCNT, B_CURADDR, B_CURCNT,
                     B_STATUS, -1, -1, -1, -1, B_TEMP, -1, -1};

  logic modelFF, modelInAccess;

  dma_reg_access_decoder dut (
    .CLK                        (CLK),
    .RESET_N                    (RESET_N),
    .CS_N                       (CS_N),
    .IOR_N                      (IOR_N),
    .IOW_N                      (IOW_N),
    .A                          (A),
    .programCondition           (programCondition),
    .loadCommandReg             (loadCommandReg),
    .readStatusReg              (readStatusReg),
    .loadIoDataBufferFromStatus (loadIoDataBufferFromStatus),
    .loadRequestReg             (loadRequestReg),
    .loadSingleMask             (loadSingleMask),
    .loadModeReg                (loadModeReg),
    .clearInternalFF            (clearInternalFF),
    .masterClear                (masterClear),
    .readTemporaryReg           (readTemporaryReg),
    .clearMaskReg               (clearMaskReg),
    .loadAllMask                (loadAllMask),
    .loadBaseAddressReg         (loadBaseAddressReg),
    .loadBaseWordCountReg       (loadBaseWordCountReg),
    .readCurrentAddressReg      (readCurrentAddressReg),
    .readCurrentWordCountReg    (readCurrentWordCountReg),
    .channelSel                 (channelSel),
    .internalFF                 (internalFF)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [14:0] expStrobes();
    logic [14:0] e;
    logic        active, isWr, isRd;
    e      = '0;
    active = RESET_N && !CS_N && programCondition;
    isWr   = active && !IOW_N && IOR_N;
    isRd   = active && !IOR_N && IOW_N;
    if (isWr) e[wrBit[A]] = 1'b1;
    if (isRd && rdBit[A] >= 0) e[rdBit[A]] = 1'b1;
    if (isRd && A == 4'h8) e[B_IOBUF] = 1'b1;
    return e;
  endfunction

  function automatic logic isChannelCycle(input logic [14:0] e);
    return e[B_BASEADDR] | e[B_BASECNT] | e[B_CURADDR] | e[B_CURCNT];
  endfunction

  task automatic checkValue(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    logic [14:0] e, obs;
    e   = expStrobes();
    obs = {loadCommandReg, readStatusReg, loadIoDataBufferFromStatus, loadRequestReg,
           loadSingleMask, loadModeReg, clearInternalFF, masterClear, readTemporaryReg,
           clearMaskReg, loadAllMask, loadBaseAddressReg, loadBaseWordCountReg,
           readCurrentAddressReg, readCurrentWordCountReg};
    checkValue({tag, ".strobes"}, obs, e);
    checkValue({tag, ".chSel"}, {13'b0, channelSel}, isChannelCycle(e) ? {13'b0, A[2:1]} : 15'd0);
    checkValue({tag, ".ff"}, {14'b0, internalFF}, {14'b0, modelFF});
  endtask

  // Reference model advances at each rising edge using the inputs held that cycle.
  task automatic modelEdge();
    logic [14:0] e;
    logic        nowAcc;
    if (!RESET_N) begin
      modelFF       = 1'b0;
      modelInAccess = 1'b0;
    end else begin
      e      = expStrobes();
      nowAcc = isChannelCycle(e);
      if (e[B_CLRFF] || e[B_MCLR]) modelFF = 1'b0;
      else if (modelInAccess && !nowAcc) modelFF = ~modelFF;
      modelInAccess = nowAcc;
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic cs, input logic ior, input logic iow,
                               input logic [3:0] addr, input logic pc, input string tag);
    @(posedge CLK);
    modelEdge();
    @(negedge CLK);
    RESET_N = rstN; CS_N = cs; IOR_N = ior; IOW_N = iow; A = addr; programCondition = pc;
    if (!rstN) begin
      modelFF       = 1'b0;
      modelInAccess = 1'b0;
    end
    #1 checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b1, tag);
  endtask

  initial begin
    logic startFF;
    RESET_N = 1'b1; CS_N = 1'b1; IOR_N = 1'b1; IOW_N = 1'b1; A = 4'h0; programCondition = 1'b0;
    modelFF = 1'b0; modelInAccess = 1'b0;
    #2 RESET_N = 1'b0;

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, "rstHold");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h8, 1'b1, "rstRelease");
    checkValue("rstReleaseCmd", {14'b0, loadCommandReg}, 15'd1);
    idle("idle0");

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 1'b1, "readStatus");
    checkValue("readStatusIoBuf", {14'b0, loadIoDataBufferFromStatus}, 15'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0, "readStatusNoProg");

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, "ch1Write1");
    checkValue("ch1Write1Ff", {14'b0, internalFF}, 15'd0);
    idle("ch1Gap");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 1'b1, "ch1Write2");
    checkValue("ch1Write2Ff", {14'b0, internalFF}, 15'd1);
    checkValue("ch1Write2Sel", {13'b0, channelSel}, 15'd1);
    idle("ch1After1");
    idle("ch1After2");
    checkValue("ch1AfterFf", {14'b0, internalFF}, 15'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 1'b1, "preClr");
    idle("preClrA");
    idle("preClrB");
    checkValue("preClrFf", {14'b0, internalFF}, 15'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hC, 1'b1, "clearFF");
    idle("postClr");
    checkValue("postClrFf", {14'b0, internalFF}, 15'd0);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "preMclr");
    idle("preMclrA");
    idle("preMclrB");
    checkValue("preMclrFf", {14'b0, internalFF}, 15'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'hD, 1'b1, "masterClear");
    checkValue("masterClearPulse", {14'b0, masterClear}, 15'd1);
    idle("postMclr");
    checkValue("postMclrFf", {14'b0, internalFF}, 15'd0);

    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'(a), 1'b1, "sweepRead");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'(a), 1'b1, "sweepWrite");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'(a), 1'b1, "sweepBothLow");
    end
    idle("sweepEndA");
    idle("sweepEndB");

    startFF = internalFF;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h1, 1'b1, "longWrite");
      checkValue("longWriteFf", {14'b0, internalFF}, {14'b0, startFF});
    end
    idle("longEndA");
    idle("longEndB");
    checkValue("longEndFf", {14'b0, internalFF}, {14'b0, ~startFF});

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, "midRstAcc");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 1'b1, "midRstHold");
    idle("midRstRelA");
    idle("midRstRelB");

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 1'b1, "progDropAcc");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, "progDrop");
    idle("progDropEnd");

    for (int i = 0; i < 400; i++) begin
      logic [1:0] strobeSel;
      strobeSel = 2'($urandom_range(3));
      applyStimulus(($urandom_range(49) != 0), ($urandom_range(3) == 0),
                    strobeSel[0], strobeSel[1], 4'($urandom_range(15)),
                    ($urandom_range(7) != 0), "random");
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
